// File: rtl/spi_dac_multi.sv
// Multi-channel SPI DAC driver: serialises {ctrl, sample} frames for each enabled
// channel in ascending order, with sync_n gaps between frames.
module spi_dac_multi #(
  parameter int DATA_W   = 16,
  parameter int CTRL_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int CLK_DIV  = 2,
  parameter int IDLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*CTRL_W-1:0] in_ctrl,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic                     sclk,
  output logic                     sync_n,
  output logic                     sdo,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int FRAME_W = CTRL_W + DATA_W;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int DIV_W   = $clog2(2 * CLK_DIV);
  localparam int GAP_W   = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  // The IDLE cycle itself counts toward the final gap, so the last GAP is one shorter.
  localparam logic [GAP_W-1:0] GAP_MORE = GAP_W'(IDLE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'((IDLE_CYC > 1) ? IDLE_CYC - 2 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [FRAME_W-1:0]       shreg_q, shreg_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH*CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                     done_q, done_d;

  logic [NUM_CH-1:0]        src_mask, rest_mask;
  logic [NUM_CH*DATA_W-1:0] src_data;
  logic [NUM_CH*CTRL_W-1:0] src_ctrl;
  logic [CH_W-1:0]          pick;
  logic [FRAME_W-1:0]       next_frame;
  logic                     accept, start_frame;

  assign accept = in_valid && in_ready;

  // Lowest pending channel, taken from the live inputs on accept, else from the latched copy.
  always_comb begin
    src_mask = (state_q == S_IDLE) ? ch_en   : mask_q;
    src_data = (state_q == S_IDLE) ? in_data : data_q;
    src_ctrl = (state_q == S_IDLE) ? in_ctrl : ctrl_q;
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (src_mask[k]) pick = CH_W'(k);
    end
    rest_mask       = src_mask;
    rest_mask[pick] = 1'b0;
    next_frame = {src_ctrl[int'(pick)*CTRL_W +: CTRL_W], src_data[int'(pick)*DATA_W +: DATA_W]};
  end

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    div_d       = div_q;
    gap_d       = gap_q;
    shreg_d     = shreg_q;
    mask_d      = mask_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    done_d      = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = in_data;
          ctrl_d = in_ctrl;
          if (|ch_en) start_frame = 1'b1;
          else begin
            mask_d = '0;
            done_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            gap_d = '0;
            if ((|mask_q) || (IDLE_CYC > 1)) state_d = S_GAP;
            else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == ((|mask_q) ? GAP_MORE : GAP_END)) begin
          if (|mask_q) start_frame = 1'b1;
          else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d = S_SHIFT;
      shreg_d = next_frame;
      mask_d  = rest_mask;
      bit_d   = '0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
    end
  end

  // Serial lines decode straight from registered state; sclk idles high.
  assign sync_n     = (state_q != S_SHIFT);
  assign sclk       = (state_q != S_SHIFT) || (div_q < DIV_HALF);
  assign sdo        = (state_q == S_SHIFT) && shreg_q[FRAME_W-1];
  assign in_ready   = !rst && (state_q == S_IDLE);
  assign busy       = !rst && (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule
